// File: rtl/load_align_unit_if.sv
// Load-path bus: the request/response handshake towards the core plus the
// word-read port towards data memory. The controls package carries the
// memory-operation encoding shared by the core and this unit.

package controls;
    typedef enum logic [3:0] {
        MEM_LB   = 4'd0,
        MEM_LH   = 4'd1,
        MEM_LW   = 4'd2,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd8,
        MEM_SH   = 4'd9,
        MEM_SW   = 4'd10,
        MEM_NONE = 4'd15
    } mem_op;
endpackage

interface load_align_unit_if #(
    parameter int Word_size = 32,
    parameter int Addr_size = 32
) ();
    // core side
    logic                 req_valid;
    logic                 req_ready;
    controls::mem_op      req_op;
    logic [Addr_size-1:0] req_addr;
    logic                 resp_valid;
    logic [Word_size-1:0] resp_data;
    logic                 resp_fault;
    // memory side
    logic                 mem_req;
    logic [Addr_size-1:0] mem_addr;
    logic                 mem_rvalid;
    logic [Word_size-1:0] mem_rdata;

    // the load unit
    modport slave (
        input  req_valid, req_op, req_addr, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_fault, mem_req, mem_addr
    );

    // the core + memory environment around the load unit
    modport master (
        output req_valid, req_op, req_addr, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_fault, mem_req, mem_addr
    );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: sequential load path between the memory stage and a
// word-organised data memory. One load in flight; one word read, or two for a
// load that straddles a word boundary; result is the selected byte/half/word
// sign- or zero-extended to Word_size (32 or 64).
// Build option: define MISALIGNED_SPLIT_EN to serve boundary-crossing loads as
// two reads; otherwise they are answered with a fault and no memory access.

module load_align_unit
    import controls::*;
#(
    parameter int Word_size = 32,
    parameter int Addr_size = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_align_unit_if.slave  bus
);

    localparam int NB = Word_size / 8;
    localparam int OW = $clog2(NB);
    localparam int BW = Addr_size - OW;

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD0  = 2'd1,
        S_RD1  = 2'd2,
        S_RESP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD0  = 2'd1,
        S_RESP = 2'd3
    } state_t;
`endif

    state_t               state_reg;
    state_t               state_next;

    // request context latched at accept
    mem_op                op_reg;
    logic [OW-1:0]        off_reg;
    logic [BW-1:0]        base_reg;
`ifdef MISALIGNED_SPLIT_EN
    logic                 cross_reg;
    logic [Word_size-1:0] lo_reg;
`endif

    logic [Word_size-1:0] resp_data_reg;
    logic                 resp_fault_reg;

    // request decode
    logic                 accept;
    logic                 req_legal;
    logic [2:0]           req_size;
    logic [OW-1:0]        req_off;
    logic                 req_cross;

    // response construction
    logic                 resp_load;
    logic                 resp_fault_next;
    logic [Word_size-1:0] resp_data_next;
    logic [Word_size-1:0] ext_lo;
    logic [Word_size-1:0] ext_hi;
    logic [Word_size-1:0] ext_data;
    logic [7:0]           merged [2*NB];
    logic [7:0]           sel_b  [4];
    logic [31:0]          sel32;

    assign accept  = bus.req_valid && bus.req_ready;
    assign req_off = bus.req_addr[OW-1:0];

    // Access size and legality of the incoming operation; stores and other
    // encodings are not loads and are answered with a fault.
    always_comb begin
        req_size  = 3'd1;
        req_legal = 1'b0;
        case (bus.req_op)
            MEM_LB, MEM_LBU: begin req_size = 3'd1; req_legal = 1'b1; end
            MEM_LH, MEM_LHU: begin req_size = 3'd2; req_legal = 1'b1; end
            MEM_LW:          begin req_size = 3'd4; req_legal = 1'b1; end
            default:         begin req_size = 3'd1; req_legal = 1'b0; end
        endcase
        req_cross = (int'(req_off) + int'(req_size)) > NB;
    end

    // The second word is never stored: it is merged straight from the bus on
    // the edge that completes the RD1 read, while the first word comes from lo_reg.
`ifdef MISALIGNED_SPLIT_EN
    assign ext_lo = (state_reg == S_RD1) ? lo_reg : bus.mem_rdata;
    assign ext_hi = (state_reg == S_RD1) ? bus.mem_rdata : '0;
`else
    assign ext_lo = bus.mem_rdata;
    assign ext_hi = '0;
`endif

    genvar gi;

    // Byte view of {hi, lo}, lowest address first.
    generate
        for (gi = 0; gi < NB; gi++) begin : g_merge
            assign merged[gi]      = ext_lo[8*gi +: 8];
            assign merged[NB + gi] = ext_hi[8*gi +: 8];
        end
    endgenerate

    // The four bytes starting at the load offset; at most a word is ever used.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            logic [OW:0] idx;
            assign idx       = {1'b0, off_reg} + (OW+1)'(gi);
            assign sel_b[gi] = merged[idx];
        end
    endgenerate

    assign sel32 = {sel_b[3], sel_b[2], sel_b[1], sel_b[0]};

    // Size selection and sign/zero extension to the data width.
    always_comb begin
        ext_data = '0;
        case (op_reg)
            MEM_LB:  ext_data = Word_size'($signed(sel32[7:0]));
            MEM_LBU: ext_data = Word_size'(sel32[7:0]);
            MEM_LH:  ext_data = Word_size'($signed(sel32[15:0]));
            MEM_LHU: ext_data = Word_size'(sel32[15:0]);
            MEM_LW:  ext_data = Word_size'($signed(sel32));
            default: ext_data = '0;
        endcase
    end

    // Next-state logic; resp_load marks the edge that enters RESP and so
    // updates the registered response.
    always_comb begin
        state_next      = state_reg;
        resp_load       = 1'b0;
        resp_fault_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (!req_legal) begin
                        state_next      = S_RESP;
                        resp_load       = 1'b1;
                        resp_fault_next = 1'b1;
`ifndef MISALIGNED_SPLIT_EN
                    end else if (req_cross) begin
                        state_next      = S_RESP;
                        resp_load       = 1'b1;
                        resp_fault_next = 1'b1;
`endif
                    end else begin
                        state_next = S_RD0;
                    end
                end
            end
            S_RD0: begin
                if (bus.mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (cross_reg) begin
                        state_next = S_RD1;
                    end else begin
                        state_next = S_RESP;
                        resp_load  = 1'b1;
                    end
`else
                    state_next = S_RESP;
                    resp_load  = 1'b1;
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            S_RD1: begin
                if (bus.mem_rvalid) begin
                    state_next = S_RESP;
                    resp_load  = 1'b1;
                end
            end
`endif
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        resp_data_next = resp_fault_next ? '0 : ext_data;
    end

    // State register and request context; reset discards any in-flight load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            op_reg    <= MEM_LB;
            off_reg   <= '0;
            base_reg  <= '0;
`ifdef MISALIGNED_SPLIT_EN
            cross_reg <= 1'b0;
            lo_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg   <= bus.req_op;
                off_reg  <= req_off;
                base_reg <= bus.req_addr[Addr_size-1:OW];
`ifdef MISALIGNED_SPLIT_EN
                cross_reg <= req_cross;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            if (state_reg == S_RD0 && bus.mem_rvalid) begin
                lo_reg <= bus.mem_rdata;
            end
`endif
        end
    end

    // Registered response; holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_reg  <= '0;
            resp_fault_reg <= 1'b0;
        end else if (resp_load) begin
            resp_data_reg  <= resp_data_next;
            resp_fault_reg <= resp_fault_next;
        end
    end

    // Word address presented to memory; the second read wraps at the top.
    always_comb begin
        bus.mem_addr = '0;
        case (state_reg)
            S_RD0:   bus.mem_addr = {base_reg, {OW{1'b0}}};
`ifdef MISALIGNED_SPLIT_EN
            S_RD1:   bus.mem_addr = {base_reg + BW'(1), {OW{1'b0}}};
`endif
            default: bus.mem_addr = '0;
        endcase
    end

`ifdef MISALIGNED_SPLIT_EN
    assign bus.mem_req = (state_reg == S_RD0) || (state_reg == S_RD1);
`else
    assign bus.mem_req = (state_reg == S_RD0);
`endif
    assign bus.req_ready  = (state_reg == S_IDLE) && !rst;
    assign bus.resp_valid = (state_reg == S_RESP);
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_fault = resp_fault_reg;

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised load path between the core's memory stage and the word-organised data memory. It accepts one load request at a time, fetches one word, or two words for a load that crosses a word boundary, from data memory over a req/rvalid handshake. It returns the selected byte, half or word, sign- or zero-extended to `Word_size`. It is the sequential successor to the combinational sign/zero extender: it adds a request/response handshake, a wait-state-tolerant memory interface, `Word_size` ∈ {32, 64}, and split handling of boundary-crossing loads.

## Interface

Parameters:
- `Word_size`, 32: data width; legal values 32 or 64. `NB = Word_size/8`; `OW = $clog2(NB)`.
- `Addr_size`, 32: byte-address width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  load request present.
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  `controls::mem_op`  LB / LBU / LH / LHU / LW.
- `req_addr`  in  `Addr_size`  byte address.
- `mem_req`  out  1  word read request; held until `mem_rvalid`.
- `mem_addr`  out  `Addr_size`  word-aligned address; low `OW` bits are 0.
- `mem_rvalid`  in  1  `mem_rdata` valid; may assert in the same cycle as `mem_req`.
- `mem_rdata`  in  `Word_size`  word read data.
- `resp_valid`  out  1  one-cycle pulse; response present.
- `resp_data`  out  `Word_size`  extended load result.
- `resp_fault`  out  1  request could not be served.

## Operation

States and transitions:
- **IDLE**: `req_ready=1`. On `req_valid`, latch `req_op`, `req_addr`, offset `off = req_addr[OW-1:0]` and `size` (1, 2 or 4 bytes). `cross = (off + size > NB)`.
  - Illegal `req_op` (any other `mem_op` value): go to RESP with fault.
  - `cross` and `MISALIGNED_SPLIT_EN` undefined: go to RESP with fault.
  - Otherwise: go to RD0.
- **RD0**: `mem_req=1`, `mem_addr = {req_addr[Addr_size-1:OW], OW'b0}`. On `mem_rvalid`, capture `lo = mem_rdata`. If `cross`, go to RD1; else go to RESP.
- **RD1**: `mem_req=1`, `mem_addr = RD0 address + NB`, modulo `2^Addr_size` (top-of-memory wraps to 0). On `mem_rvalid`, capture `hi`, go to RESP.
- **RESP**: `resp_valid=1`, `req_ready=0`. Next state is IDLE.

Data and extension:
- Selection: `sel = ({hi, lo} >> (off*8))`. `hi` is 0 when there is no second read.
- LB / LBU take `sel[7:0]`; LH / LHU take `sel[15:0]`; LW takes `sel[31:0]`.
- LB, LH and LW sign-extend to `Word_size`; LBU and LHU zero-extend. For `Word_size`=32, LW is a pass-through.
- A fault response drives `resp_fault=1` and `resp_data=0`, with no memory access.

Hold and reset:
- `resp_data` and `resp_fault` are registered and hold their last values outside `resp_valid`.
- Reset values: state IDLE, `req_ready=0` while `rst` is high (1 from the first cycle after release), `mem_req=0`, `mem_addr=0`, `resp_valid=0`, `resp_data=0`, `resp_fault=0`.

## Timing

- Request handshake: accepted on the edge where `req_valid && req_ready`. `req_*` is sampled only then.
- Aligned load, zero-wait memory: accept at cycle 0, RD0 at cycle 1, `resp_valid` at cycle 2.
- Crossing load: `resp_valid` at cycle 3, plus any memory wait cycles.
- Memory wait states: every cycle without `mem_rvalid` in RD0/RD1 adds one cycle. `mem_req` and `mem_addr` stay stable throughout.
- `mem_rvalid` outside RD0/RD1 is ignored.
- Back-to-back requests: the earliest next accept is the cycle after RESP. Throughput is at most one load per 3 cycles.
- Reset mid-operation: `rst` high in any state forces IDLE on that edge. In-flight data is discarded and no `resp_valid` is produced. A late `mem_rvalid` is ignored.
- Fault response: `resp_valid` is asserted the cycle after accept; `mem_req` never asserts.

## Configuration

- `MISALIGNED_SPLIT_EN` defined: boundary-crossing loads are served as two sequential word reads, RD0 then RD1, and merged.
- `MISALIGNED_SPLIT_EN` undefined:
  - The RD1 state and the `hi` register are not built.
  - Crossing loads return `resp_fault=1` and `resp_data=0` one cycle after accept, with no `mem_req`.
  - Misaligned loads that stay within one word are served normally in both builds.

## Test plan

- **Byte/half loads** (`Word_size`=32, word 0xFF810FF0, zero-wait memory):
  - LB at offset 2 → 0xFFFFFF81; LBU at offset 2 → 0x00000081.
  - LH at offset 2 → 0xFFFFFF81; LHU at offset 0 → 0x00000FF0.
  - LW at offset 0 → 0xFF810FF0.
  - Each `resp_valid` appears 2 cycles after accept.
- **Wait states**: LW at 0x100 with `mem_rvalid` delayed 3 cycles → `mem_req` and `mem_addr`=0x100 stable for 4 cycles; `resp_valid` at cycle 5.
- **Crossing loads** (`MISALIGNED_SPLIT_EN`; word@0x1000=0x44332211, word@0x1004=0x88776655):
  - LW at 0x1001 → reads 0x1000 then 0x1004; `resp_data`=0x55443322 at cycle 3.
  - LH at 0x1003 → 0x00005544.
- **Split disabled**: same LW at 0x1001 without the macro → `resp_fault=1`, `resp_data=0` at cycle 1, `mem_req` never high.
- **64-bit build**: `Word_size`=64, word 0x80000000_12345678.
  - LW at offset 4 → 0xFFFFFFFF_80000000.
  - LHU at offset 6 → 0x00000000_00008000.
- **Reset and illegal op**:
  - `rst` pulsed while in RD1 → IDLE, no `resp_valid`, `mem_req=0` next cycle; a subsequent LB proceeds normally.
  - Illegal `req_op` → `resp_fault=1` with no `mem_req`.
